// File: rtl/sipo_framed.sv
// Framed serial-in / parallel-out shift register with a double-buffered output word.
// Serial bits are shifted in while in_bit_valid is high. A bit with in_frame set always
// starts a new word. The parallel word is handed off through a valid/ready holding
// register, and the block reports overruns and resync aborts.
module sipo_framed #(
    parameter int unsigned BITS        = 8,
    parameter bit          SHIFT_RIGHT = 1'b1
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_serial,
    input  logic                   in_bit_valid,
    input  logic                   in_frame,
    output logic [BITS-1:0]        out_parallel,
    output logic                   out_valid,
    input  logic                   in_ready,
    output logic                   out_busy,
    output logic [$clog2(BITS):0]  out_bitcount,
    output logic                   out_overrun,
    output logic                   out_frame_err,
    input  logic                   in_clr_err
);

    localparam int unsigned CntW = $clog2(BITS) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BITS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e            state_q;
    logic [BITS-1:0]   shreg_q;
    logic [CntW-1:0]   cnt_q;
    logic [BITS-1:0]   hold_q;
    logic              valid_q;
    logic              ovr_q;
    logic              ferr_q;

    logic [BITS-1:0]   first_word;
    logic [BITS-1:0]   next_word;
    logic              bit_start;
    logic              bit_take;
    logic              complete;
    logic              handshake;
    logic              accept_word;

    // Shift-register images: word holding only the new bit, and the register after one shift.
    always_comb begin
        if (SHIFT_RIGHT) begin
            first_word = {in_serial, {(BITS-1){1'b0}}};
            next_word  = {in_serial, shreg_q[BITS-1:1]};
        end else begin
            first_word = {{(BITS-1){1'b0}}, in_serial};
            next_word  = {shreg_q[BITS-2:0], in_serial};
        end
    end

    // Decode the per-cycle events that drive the FSM and the output buffer.
    always_comb begin
        bit_start   = in_bit_valid && in_frame;
        bit_take    = in_bit_valid && !in_frame;
        complete    = (state_q == StShift) && bit_take && (cnt_q == LastCnt);
        handshake   = valid_q && in_ready;
        // A completed word gets in if the buffer is empty or is drained on this same edge.
        accept_word = complete && (!valid_q || in_ready);
    end

    // Receive FSM, shift register, holding register and status flags.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ferr_q <= 1'b0;

            // The load below overrides the clear when a new word lands on a handshake edge.
            if (handshake) begin
                valid_q <= 1'b0;
            end
            if (accept_word) begin
                hold_q  <= next_word;
                valid_q <= 1'b1;
            end

            // Setting an overrun wins over a simultaneous clear request.
            if (complete && !accept_word) begin
                ovr_q <= 1'b1;
            end else if (in_clr_err) begin
                ovr_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (bit_start) begin
                        shreg_q <= first_word;
                        cnt_q   <= CntW'(1);
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (bit_start) begin
                        // Resync: drop the partial word and restart on this bit.
                        ferr_q  <= 1'b1;
                        shreg_q <= first_word;
                        cnt_q   <= CntW'(1);
                    end else if (bit_take) begin
                        shreg_q <= next_word;
                        if (cnt_q == LastCnt) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_parallel  = hold_q;
    assign out_valid     = valid_q;
    assign out_busy      = (state_q == StShift);
    assign out_bitcount  = cnt_q;
    assign out_overrun   = ovr_q;
    assign out_frame_err = ferr_q;

endmodule

// File: tb/tb_sipo_framed.sv
// Bench for sipo_framed: one LSB-first and one MSB-first instance driven in parallel,
// compared against a queue-based word-level reference model.
module tb_sipo_framed;

    localparam int unsigned BITS = 8;
    localparam int unsigned CW   = $clog2(BITS) + 1;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic serial = 1'b0;
    logic bv     = 1'b0;
    logic frame  = 1'b0;
    logic ready  = 1'b0;
    logic clr    = 1'b0;

    logic [BITS-1:0] par_l, par_m;
    logic            val_l, val_m, busy_l, busy_m, ovr_l, ovr_m, fe_l, fe_m;
    logic [CW-1:0]   cnt_l, cnt_m;

    int n_cmp = 0;
    int n_err = 0;

    sipo_framed #(.BITS(BITS), .SHIFT_RIGHT(1'b1)) u_lsb (
        .in_clk       (clk),
        .in_rst       (rst_n),
        .in_serial    (serial),
        .in_bit_valid (bv),
        .in_frame     (frame),
        .out_parallel (par_l),
        .out_valid    (val_l),
        .in_ready     (ready),
        .out_busy     (busy_l),
        .out_bitcount (cnt_l),
        .out_overrun  (ovr_l),
        .out_frame_err(fe_l),
        .in_clr_err   (clr)
    );

    sipo_framed #(.BITS(BITS), .SHIFT_RIGHT(1'b0)) u_msb (
        .in_clk       (clk),
        .in_rst       (rst_n),
        .in_serial    (serial),
        .in_bit_valid (bv),
        .in_frame     (frame),
        .out_parallel (par_m),
        .out_valid    (val_m),
        .in_ready     (ready),
        .out_busy     (busy_m),
        .out_bitcount (cnt_m),
        .out_overrun  (ovr_m),
        .out_frame_err(fe_m),
        .in_clr_err   (clr)
    );

    always #5 clk = ~clk;

    // Reference model: bits received so far in arrival order, plus the delivered word.
    bit              m_bits[$];
    logic [BITS-1:0] m_word_l;
    logic [BITS-1:0] m_word_m;
    bit              m_valid;
    bit              m_ovr;
    bit              m_ferr;

    task automatic model_reset();
        m_bits.delete();
        m_word_l = '0;
        m_word_m = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_ferr   = 1'b0;
    endtask

    task automatic model_step();
        bit completed;
        bit took;
        completed = 1'b0;
        took      = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_ferr = 1'b0;
        if (bv) begin
            if (frame) begin
                if (m_bits.size() != 0) m_ferr = 1'b1;
                m_bits.delete();
                m_bits.push_back(serial);
            end else if (m_bits.size() != 0) begin
                m_bits.push_back(serial);
                if (m_bits.size() == BITS) completed = 1'b1;
            end
        end
        if (completed) begin
            if (!m_valid || ready) begin
                m_word_l = '0;
                m_word_m = '0;
                for (int i = 0; i < BITS; i++) begin
                    m_word_l[i]          = m_bits[i];
                    m_word_m[BITS-1-i]   = m_bits[i];
                end
                m_valid = 1'b1;
                took    = 1'b1;
            end
            m_bits.delete();
        end
        if (m_valid && ready && !took) m_valid = 1'b0;
        if (completed && !took) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Sends vec[0] first; in_frame on the first bit when with_frame is set.
    task automatic send_bits(input logic [63:0] vec, input int n, input bit with_frame);
        for (int i = 0; i < n; i++) begin
            serial = vec[i];
            bv     = 1'b1;
            frame  = with_frame && (i == 0);
            tick();
        end
        bv    = 1'b0;
        frame = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if ({par_l, val_l, busy_l, cnt_l, ovr_l, fe_l} !== '0) begin
            n_err++;
            $display("FAIL reset_lsb: got %h/%b/%b/%0d/%b/%b required all zero",
                     par_l, val_l, busy_l, cnt_l, ovr_l, fe_l);
        end
        n_cmp++;
        if ({par_m, val_m, busy_m, cnt_m, ovr_m, fe_m} !== '0) begin
            n_err++;
            $display("FAIL reset_msb: got %h/%b/%b/%0d/%b/%b required all zero",
                     par_m, val_m, busy_m, cnt_m, ovr_m, fe_m);
        end
        serial = 1'b1;
        bv     = 1'b1;
        frame  = 1'b1;
        tick();
        n_cmp++;
        if ({busy_l, cnt_l, busy_m, cnt_m} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: busy/cnt got %b/%0d %b/%0d required 0/0",
                     busy_l, cnt_l, busy_m, cnt_m);
        end
        bv    = 1'b0;
        frame = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lsb_a5();
        logic [7:0] vec;
        vec   = 8'hA5;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serial = vec[i];
            bv     = 1'b1;
            frame  = (i == 0);
            tick();
            if (i < 7) begin
                n_cmp++;
                if (val_l !== 1'b0) begin
                    n_err++;
                    $display("FAIL a5_early_valid bit %0d: got %b required 0", i, val_l);
                end
            end
        end
        bv = 1'b0;
        n_cmp++;
        if (val_l !== 1'b1 || par_l !== 8'hA5) begin
            n_err++;
            $display("FAIL a5_word: got valid %b data %h required 1 a5", val_l, par_l);
        end
        n_cmp++;
        if (val_m !== 1'b1 || par_m !== m_word_m) begin
            n_err++;
            $display("FAIL a5_msb_word: got valid %b data %h required 1 %h", val_m, par_m,
                     m_word_m);
        end
        tick();
        n_cmp++;
        if (val_l !== 1'b0) begin
            n_err++;
            $display("FAIL a5_valid_one_cycle: got %b required 0", val_l);
        end
    endtask

    task automatic test_msb_3c();
        logic [7:0]    word;
        logic [CW-1:0] ecnt;
        int            gap;
        word  = 8'h3C;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bv     = 1'b0;
                serial = 1'($urandom);
                frame  = 1'($urandom);
                tick();
                ecnt = CW'(i);
                n_cmp++;
                if (cnt_m !== ecnt) begin
                    n_err++;
                    $display("FAIL 3c_gap_hold bit %0d: got %0d required %0d", i, cnt_m, ecnt);
                end
            end
            serial = word[7-i];
            bv     = 1'b1;
            frame  = (i == 0);
            tick();
            ecnt = (i == 7) ? CW'(0) : CW'(i + 1);
            n_cmp++;
            if (cnt_m !== ecnt) begin
                n_err++;
                $display("FAIL 3c_bitcount bit %0d: got %0d required %0d", i, cnt_m, ecnt);
            end
        end
        bv    = 1'b0;
        frame = 1'b0;
        n_cmp++;
        if (val_m !== 1'b1 || par_m !== 8'h3C) begin
            n_err++;
            $display("FAIL 3c_word: got valid %b data %h required 1 3c", val_m, par_m);
        end
        n_cmp++;
        if (par_l !== m_word_l) begin
            n_err++;
            $display("FAIL 3c_lsb_word: got %h required %h", par_l, m_word_l);
        end
        tick();
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send_bits(64'h11, 8, 1'b1);
        n_cmp++;
        if (val_l !== 1'b1 || par_l !== 8'h11) begin
            n_err++;
            $display("FAIL ovr_first: got valid %b data %h required 1 11", val_l, par_l);
        end
        send_bits(64'h22, 8, 1'b1);
        n_cmp++;
        if (par_l !== 8'h11 || ovr_l !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_keep: got data %h ovr %b required 11 1", par_l, ovr_l);
        end
        n_cmp++;
        if (par_m !== m_word_m || ovr_m !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_msb: got data %h ovr %b required %h 1", par_m, ovr_m, m_word_m);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (ovr_l !== 1'b0 || ovr_m !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got %b %b required 0 0", ovr_l, ovr_m);
        end
        // Clear request on the same edge as a fresh overrun: the overrun must stick.
        send_bits(64'h33, 7, 1'b1);
        clr = 1'b1;
        send_bits(64'h33 >> 7, 1, 1'b0);
        clr = 1'b0;
        n_cmp++;
        if (ovr_l !== 1'b1 || par_l !== 8'h11) begin
            n_err++;
            $display("FAIL ovr_clr_collide: got ovr %b data %h required 1 11", ovr_l, par_l);
        end
        clr   = 1'b1;
        ready = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (val_l !== 1'b0 || ovr_l !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_drain: got valid %b ovr %b required 0 0", val_l, ovr_l);
        end
    endtask

    task automatic test_frame_err();
        logic [10:0] vec;
        int          fe_hits;
        int          v_hits;
        vec     = {8'h5A, 3'($urandom)};
        fe_hits = 0;
        v_hits  = 0;
        ready   = 1'b1;
        for (int i = 0; i < 11; i++) begin
            serial = vec[i];
            bv     = 1'b1;
            frame  = (i == 0) || (i == 3);
            tick();
            fe_hits += int'(fe_l);
            v_hits  += int'(val_l);
            if (i == 3) begin
                n_cmp++;
                if (fe_l !== 1'b1 || cnt_l !== CW'(1)) begin
                    n_err++;
                    $display("FAIL ferr_pulse: got ferr %b cnt %0d required 1 1", fe_l, cnt_l);
                end
            end
        end
        bv    = 1'b0;
        frame = 1'b0;
        n_cmp++;
        if (val_l !== 1'b1 || par_l !== 8'h5A) begin
            n_err++;
            $display("FAIL ferr_word: got valid %b data %h required 1 5a", val_l, par_l);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            fe_hits += int'(fe_l);
            v_hits  += int'(val_l);
        end
        n_cmp++;
        if (fe_hits != 1 || v_hits != 1) begin
            n_err++;
            $display("FAIL ferr_counts: got ferr cycles %0d valid cycles %0d required 1 1",
                     fe_hits, v_hits);
        end
    endtask

    task automatic test_reset_mid();
        send_bits(64'($urandom), 5, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({par_l, val_l, busy_l, cnt_l, ovr_l, fe_l,
             par_m, val_m, busy_m, cnt_m, ovr_m, fe_m} !== '0) begin
            n_err++;
            $display("FAIL midreset_async: lsb %h/%b/%b/%0d msb %h/%b/%b/%0d required zero",
                     par_l, val_l, busy_l, cnt_l, par_m, val_m, busy_m, cnt_m);
        end
        tick();
        tick();
        rst_n = 1'b1;
        send_bits(64'h5, 3, 1'b0);
        n_cmp++;
        if (busy_l !== 1'b0 || cnt_l !== '0) begin
            n_err++;
            $display("FAIL midreset_ignore: got busy %b cnt %0d required 0 0", busy_l, cnt_l);
        end
        ready = 1'b1;
        send_bits(64'hC3, 8, 1'b1);
        n_cmp++;
        if (val_l !== 1'b1 || par_l !== 8'hC3 || par_m !== m_word_m) begin
            n_err++;
            $display("FAIL midreset_word: got %b %h %h required 1 c3 %h", val_l, par_l, par_m,
                     m_word_m);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        send_bits(64'h01, 8, 1'b1);
        n_cmp++;
        if (val_l !== 1'b1 || par_l !== 8'h01 || busy_l !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: got valid %b data %h busy %b required 1 01 0",
                     val_l, par_l, busy_l);
        end
        send_bits(64'hFF, 1, 1'b1);
        n_cmp++;
        if (cnt_l !== CW'(1) || busy_l !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_nogap: got cnt %0d busy %b required 1 1", cnt_l, busy_l);
        end
        send_bits(64'h7F, 6, 1'b0);
        n_cmp++;
        if (val_l !== 1'b1 || par_l !== 8'h01) begin
            n_err++;
            $display("FAIL b2b_hold: got valid %b data %h required 1 01", val_l, par_l);
        end
        ready = 1'b1;
        send_bits(64'h1, 1, 1'b0);
        n_cmp++;
        if (val_l !== 1'b1 || par_l !== 8'hFF || ovr_l !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: got valid %b data %h ovr %b required 1 ff 0",
                     val_l, par_l, ovr_l);
        end
        tick();
        n_cmp++;
        if (val_l !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: got valid %b required 0", val_l);
        end
    endtask

    task automatic test_random();
        logic [BITS+CW+3:0] exp_l;
        logic [BITS+CW+3:0] exp_m;
        logic [BITS+CW+3:0] got_l;
        logic [BITS+CW+3:0] got_m;
        for (int c = 0; c < 1500; c++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            bv     = ($urandom_range(0, 3) != 0);
            frame  = (m_bits.size() == 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 15) == 0);
            serial = 1'($urandom);
            ready  = ($urandom_range(0, 2) != 0);
            clr    = ($urandom_range(0, 31) == 0);
            tick();
            exp_l = {m_word_l, m_valid, (m_bits.size() != 0), CW'(m_bits.size()), m_ovr, m_ferr};
            exp_m = {m_word_m, m_valid, (m_bits.size() != 0), CW'(m_bits.size()), m_ovr, m_ferr};
            got_l = {par_l, val_l, busy_l, cnt_l, ovr_l, fe_l};
            got_m = {par_m, val_m, busy_m, cnt_m, ovr_m, fe_m};
            n_cmp++;
            if (got_l !== exp_l) begin
                n_err++;
                $display("FAIL rand_lsb cycle %0d: got %h required %h", c, got_l, exp_l);
            end
            n_cmp++;
            if (got_m !== exp_m) begin
                n_err++;
                $display("FAIL rand_msb cycle %0d: got %h required %h", c, got_m, exp_m);
            end
        end
        rst_n = 1'b1;
        bv    = 1'b0;
        frame = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lsb_a5();
        test_msb_3c();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_framed.md
SIPO_FRAMED -- requirements
Module: sipo_framed

Interface
REQ-001 SHALL have parameter BITS, default 8, word width (legal range 2..64).
REQ-002 SHALL have parameter SHIFT_RIGHT, default 1: 1 = first received bit lands in bit 0 (LSB-first); 0 = first received bit lands in bit BITS-1 (MSB-first).
REQ-003 SHALL have in_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have in_rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have in_serial  input  1  serial data bit.
REQ-006 SHALL have in_bit_valid  input  1  in_serial is sampled on this edge only when 1.
REQ-007 SHALL have in_frame  input  1  qualified by in_bit_valid; marks the current bit as first bit of a word.
REQ-008 SHALL have out_parallel  output  BITS  registered received word.
REQ-009 SHALL have out_valid  output  1  out_parallel holds an unconsumed word.
REQ-010 SHALL have in_ready  input  1  consumer accepts word when out_valid && in_ready.
REQ-011 SHALL have out_busy  output  1  a word is partially received.
REQ-012 SHALL have out_bitcount  output  $clog2(BITS)+1  bits received in current word.
REQ-013 SHALL have out_overrun  output  1  sticky: completed word dropped.
REQ-014 SHALL have out_frame_err  output  1  one-cycle pulse: partial word aborted by resync.
REQ-015 SHALL have in_clr_err  input  1  synchronous clear of out_overrun.

Function
REQ-016 SHALL implement FSM states IDLE and SHIFT with a separate output holding register (double buffering).
REQ-017 IDLE: in_bit_valid && in_frame SHALL load the first bit, set out_bitcount=1, go to SHIFT; bits without in_frame SHALL be ignored.
REQ-018 SHIFT: each in_bit_valid without in_frame SHALL shift in one bit and increment out_bitcount; cycles with in_bit_valid=0 SHALL hold all state.
REQ-019 SHIFT_RIGHT=1: new bit SHALL enter at bit BITS-1, register shifts toward bit 0; SHIFT_RIGHT=0: new bit enters at bit 0, shifts toward BITS-1.
REQ-020 On the edge sampling the BITS-th bit, the full word SHALL transfer to the holding register, FSM returns to IDLE, out_bitcount=0; out_valid=1 and out_parallel valid from the following cycle (latency 1 clock after final bit).
REQ-021 out_valid SHALL stay 1 and out_parallel stable until the edge where out_valid && in_ready, which clears out_valid.
REQ-022 Word completion while out_valid=1 and in_ready=0 SHALL discard the new word, keep the old word, set out_overrun.
REQ-023 Word completion in the same cycle as a handshake SHALL load the new word, keep out_valid=1, not set out_overrun.
REQ-024 in_bit_valid && in_frame while in SHIFT SHALL discard the partial word, pulse out_frame_err for one cycle, and restart with this bit as first bit (out_bitcount=1).
REQ-025 out_overrun SHALL clear only on reset or in_clr_err=1; in_clr_err coincident with a new overrun SHALL leave out_overrun=1.
REQ-026 out_busy SHALL equal (state == SHIFT).
REQ-027 In IDLE the following frame's first bit SHALL be accepted on the cycle immediately after completion (back-to-back words, no gap bit).

Reset
REQ-028 in_rst=0 SHALL immediately force: state IDLE, shift register 0, out_parallel 0, out_valid 0, out_busy 0, out_bitcount 0, out_overrun 0, out_frame_err 0.
REQ-029 Reset mid-word SHALL discard the partial word; after release, reception starts only at the next in_frame bit.

Verification
REQ-030 BITS=8, SHIFT_RIGHT=1: send 1,0,1,0,0,1,0,1 (in_frame on first), in_ready=1 -> out_parallel=0xA5, out_valid high exactly 1 cycle, one cycle after last bit.
REQ-031 BITS=8, SHIFT_RIGHT=0: send 0,0,1,1,1,1,0,0 with random in_bit_valid gaps -> out_parallel=0x3C, out_bitcount steps 1..7 then 0.
REQ-032 in_ready=0, send 0x11 then 0x22 -> out_parallel stays 0x11, out_overrun=1; in_clr_err pulse -> out_overrun=0.
REQ-033 Send 3 bits, then in_frame with 8-bit word 0x5A -> out_frame_err one-cycle pulse, out_parallel=0x5A, no other word emitted.
REQ-034 Assert in_rst=0 after 5 bits, release, send 0xC3 -> all outputs 0 during reset, then out_parallel=0xC3.
REQ-035 Back-to-back 0x01, 0xFF with in_ready asserted on completion edge of second -> both words delivered, out_overrun=0.
